// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// State list grows by CR_PEND when UART_SCHED_CRLF_EN is defined.
package uart_sched_pkg;

`ifdef UART_SCHED_CRLF_EN
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    CR_PEND
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;
`endif

  typedef enum logic {
    SRC_LPC,
    SRC_AUX
  } src_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of LPC, aux and transmitter signals around the scheduler.
// slave = scheduler side, master = decoder/aux/transmitter side.
interface uart_tx_sched_if #(
  parameter int AW = 4
);
  logic [7:0]  lpc_tx_data;
  logic        lpc_tx_valid;
  logic        lpc_tx_busy;
  logic [7:0]  aux_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [7:0]  uart_data;
  logic        uart_start;
  logic        uart_busy;
  logic [AW:0] fifo_level;
  logic        overflow;

  modport slave (
    input  lpc_tx_data,
    input  lpc_tx_valid,
    output lpc_tx_busy,
    input  aux_data,
    input  aux_valid,
    output aux_ready,
    output uart_data,
    output uart_start,
    input  uart_busy,
    output fifo_level,
    output overflow
  );

  modport master (
    output lpc_tx_data,
    output lpc_tx_valid,
    input  lpc_tx_busy,
    output aux_data,
    output aux_valid,
    input  aux_ready,
    input  uart_data,
    input  uart_start,
    output uart_busy,
    input  fifo_level,
    input  overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO with extra-bit pointers, registered level and almost-full.
// Single clock, synchronous active-high reset.
module sync_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic        afull,
  output logic [AW:0] level
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_LVL = (AW+1)'(DEPTH - 1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level_nxt;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // next occupancy; push and pop together leave it unchanged
  always_comb begin
    level_nxt = level;
    unique case (1'b1)
      do_push && !do_pop: level_nxt = level + ONE;
      do_pop && !do_push: level_nxt = level - ONE;
      default: ;
    endcase
  end

  // storage array; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // pointers, level and almost-full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      afull  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      level <= level_nxt;
      afull <= (level_nxt >= AF_LVL);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates LPC console FIFO and aux source onto one UART transmitter.
// Define UART_SCHED_CRLF_EN to expand LPC LF bytes into CR,LF.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int MAX_BURST = 8,
  parameter int START_TMO = 4
) (
  input logic            lpc_clk,
  input logic            lpc_rst,
  uart_tx_sched_if.slave bus
);
  localparam int TW = $clog2(START_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t         state;
  src_t           sel_src;
  logic [7:0]     data_q;
  logic           start_q;
  logic           ready_q;
  logic [7:0]     burst;
  logic [TW-1:0]  tmo;
  logic           valid_q;
  logic           overflow_q;
  logic           push;
  logic           pop;
  logic           lpc_ok;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_afull;
  logic [FIFO_AW:0] fifo_level;
`ifdef UART_SCHED_CRLF_EN
  logic           lf_pend;
`endif

  assign push = bus.lpc_tx_valid && !valid_q;

  assign lpc_ok = !fifo_empty &&
                  (!bus.aux_valid || (burst < BURST_MAX));
  assign sel_src = lpc_ok ? SRC_LPC : SRC_AUX;
  assign pop = (state == IDLE) && lpc_ok;

  sync_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (lpc_clk),
    .rst   (lpc_rst),
    .push  (push),
    .din   (bus.lpc_tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .afull (fifo_afull),
    .level (fifo_level)
  );

  // strobe edge detector and sticky drop flag
  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= bus.lpc_tx_valid;
      if (push && fifo_full) overflow_q <= 1'b1;
    end
  end

  // source select, launch pulse and transmitter handshake
  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      state   <= IDLE;
      data_q  <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      burst   <= '0;
      tmo     <= '0;
`ifdef UART_SCHED_CRLF_EN
      lf_pend <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_empty) burst <= '0;
          if (lpc_ok || bus.aux_valid) begin
            state   <= LAUNCH;
            start_q <= 1'b1;
            if (sel_src == SRC_LPC) begin
              data_q <= fifo_dout;
              if (burst != 8'hFF) burst <= burst + 8'd1;
`ifdef UART_SCHED_CRLF_EN
              if (fifo_dout == ASCII_LF) begin
                data_q  <= ASCII_CR;
                lf_pend <= 1'b1;
              end
`endif
            end else begin
              data_q  <= bus.aux_data;
              ready_q <= 1'b1;
              burst   <= '0;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT_BUSY;
          tmo   <= '0;
        end
        WAIT_BUSY: begin
          if (bus.uart_busy) begin
            state <= WAIT_DONE;
          end else if (tmo == TMO_LAST) begin
`ifdef UART_SCHED_CRLF_EN
            state <= lf_pend ? CR_PEND : IDLE;
`else
            state <= IDLE;
`endif
          end else begin
            tmo <= tmo + TMO_ONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.uart_busy) begin
`ifdef UART_SCHED_CRLF_EN
            state <= lf_pend ? CR_PEND : IDLE;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef UART_SCHED_CRLF_EN
        CR_PEND: begin
          data_q  <= ASCII_LF;
          lf_pend <= 1'b0;
          start_q <= 1'b1;
          state   <= LAUNCH;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_data   = data_q;
  assign bus.uart_start  = start_q;
  assign bus.aux_ready   = ready_q;
  assign bus.lpc_tx_busy = fifo_afull;
  assign bus.fifo_level  = fifo_level;
  assign bus.overflow    = overflow_q;

endmodule
